create_d: RTL
=============

Name: create_d

Overview:
- Private-exponent generator for the RSA key path.
- Sits directly downstream of create_e and consumes its L (lcm(p-1,q-1)) and chosen public exponent E.
- Computes D = E^-1 mod L using the iterative extended Euclidean algorithm, with a sequential restoring divider and a fused quotient×coefficient accumulator. No hardware multiplier.
- Exposes D with the same active-low start/ready handshake style as create_e.

Parameters:
- W, 64: operand width of L, E, D.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- L  in  W  modulus; sampled on start
- E  in  W  exponent to invert; sampled on start
- start_n  in  1  active-low start request (level)
- D  out  W  result, 0 ≤ D < L
- ready_n  out  1  low = D/err valid
- err  out  1  high with ready_n low if no inverse exists or inputs are illegal

Behaviour:
- Reset (async, rst_n=0): state=IDLE, D=0, ready_n=1, err=0, armed=1. Internal registers cleared.
- Start:
  - Accepted in IDLE or DONE when start_n=0 and armed=1.
  - On acceptance: latch L and E; clear armed; set ready_n=1, err=0.
  - armed re-sets only after start_n is sampled 1. A start_n held low never retriggers.
  - start_n is ignored in every other state.
- Illegal inputs (E=0, L<2, or E≥L):
  - Go to DONE one cycle after start, with D=0, err=1.
- Registers:
  - r0, r1: W bits.
  - t0, t1, acc: signed W+2 bits.
  - q: W bits.
  - Init: r0=L, r1=E, t0=0, t1=1.
- States:
  - IDLE: wait for start, then go to CHECK.
  - CHECK (1 cycle): if r1==0, go to FIX. Otherwise load the divider (rem=0, dividend=r0, acc=0, bit counter=W-1) and go to DIV.
  - DIV (exactly W cycles), MSB-first restoring division of r0 by r1:
    - rem = {rem, dividend bit}.
    - If rem ≥ r1: rem -= r1, qbit=1; else qbit=0.
    - Every cycle: acc = 2·acc + (qbit ? t1 : 0).
    - After W cycles, rem = r0 mod r1 and acc = q·t1.
  - UPD (1 cycle): r0←r1, r1←rem, t0←t1, t1←t0−acc. Then go to CHECK.
  - FIX (1 cycle):
    - If r0≠1: D=0, err=1.
    - Else: D = t0<0 ? t0+L : t0 (truncated to W), err=0.
    - Then go to DONE.
  - DONE: ready_n=0. D and err stay stable until the next accepted start or reset.
- Arithmetic:
  - |t| ≤ L throughout, so W+2 signed bits are sufficient.
  - All comparisons are unsigned on W bits.
- Latency from the start-accept edge to ready_n=0:
  - Formula: 1 + n·(W+2) + 2, where n is the number of Euclid iterations (n ≤ 94 for W=64).
  - Example: L=20, E=3 gives n=3, so 201 cycles at W=64.
- Reset mid-operation: immediate abort to reset values. No partial D is ever exposed.
- Simultaneous events:
  - start_n falling in the same cycle that FIX completes is ignored (state ≠ IDLE/DONE).
  - start_n=0 in DONE with armed=1 restarts, and ready_n rises on the next edge.

Decomposition:
- Shared package rsa_pkg:
  - width constant W_KEY=64.
  - create_d state enum (IDLE, CHECK, DIV, UPD, FIX, DONE).
  - signed coefficient typedef (W+2 bits).
- Natural sub-module: seq_divacc. It is the W-cycle restoring divider with the fused acc update.
  - Inputs: load, dividend, divisor, coef.
  - Outputs: rem, acc, done.
- create_d owns the Euclid FSM, the handshake and the final fix-up.

Test Plan:
- Basic inverse: L=20, E=3, pulse start_n low one cycle → ready_n=0 after 201 cycles, D=7, err=0.
- Textbook key: L=3120, E=17 → D=2753, err=0. D stays stable while start_n is held low (no retrigger). Raising start_n, then lowering it again, restarts and yields the same D.
- No inverse and illegal inputs:
  - L=20, E=4 → D=0, err=1.
  - E=0 → err=1 one cycle after start.
  - E=25, L=20 → err=1.
- Edge values:
  - E=1, L=20 → D=1.
  - L=2^64−2, E=65537 → bench model checks (E·D) mod L == 1 and ready_n within 94·66+3 cycles.
- Reset mid-DIV: assert rst_n=0 at cycle 30 of a run → D=0, ready_n=1, err=0 asynchronously. After release, a new start with L=3120, E=17 gives D=2753.
- Back-to-back with the upstream stage: wire start_n to create_e's ready_n with random legal L → every ready_n low yields (E·D) mod L == 1, checked over 200 random L.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key path: key width, create_d FSM encoding
// and the signed Euclid coefficient type.
package rsa_pkg;

    localparam int W_KEY = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_DIV   = 3'd2,
        ST_UPD   = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } cd_state_e;

    // Bezout coefficients never exceed the modulus in magnitude, so two
    // extra bits cover both the sign and the transient q*t product.
    typedef logic signed [W_KEY+1:0] coef_t;

endpackage

// File: rtl/create_d_divacc.sv
// Sequential MSB-first restoring divider that accumulates quotient * coef on
// the fly, so the Euclid step needs no multiplier. Takes exactly W cycles.
module seq_divacc
    import rsa_pkg::*;
#(
    parameter int W = W_KEY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [W-1:0]        dividend,
    input  logic [W-1:0]        divisor,
    input  logic signed [W+1:0] coef,
    output logic [W-1:0]        rem,
    output logic signed [W+1:0] acc,
    output logic                done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]        rem_r;
    logic [W-1:0]        dvd_r;
    logic [W-1:0]        dvs_r;
    logic signed [W+1:0] coef_r;
    logic signed [W+1:0] acc_r;
    logic [CW-1:0]       cnt_r;
    logic                busy_r;

    logic [W:0]          trial_s;
    logic                ge_s;
    logic [W-1:0]        rem_next_s;
    logic signed [W+1:0] acc_next_s;

    // One restoring-division step plus the shift-and-add of the accumulator.
    always_comb begin
        trial_s = {rem_r, dvd_r[W-1]};
        ge_s    = (trial_s >= {1'b0, dvs_r});
        if (ge_s) begin
            rem_next_s = trial_s[W-1:0] - dvs_r;
            acc_next_s = (acc_r <<< 1) + coef_r;
        end else begin
            rem_next_s = trial_s[W-1:0];
            acc_next_s = acc_r <<< 1;
        end
    end

    // Divider state: load primes the registers, then W steps run unattended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= '0;
            dvd_r  <= '0;
            dvs_r  <= '0;
            coef_r <= '0;
            acc_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (load) begin
            rem_r  <= '0;
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            coef_r <= coef;
            acc_r  <= '0;
            cnt_r  <= CW'(W - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r  <= rem_next_s;
            acc_r  <= acc_next_s;
            dvd_r  <= {dvd_r[W-2:0], 1'b0};
            cnt_r  <= cnt_r - CW'(1);
            busy_r <= (cnt_r != '0);
        end else begin
            rem_r  <= rem_r;
            acc_r  <= acc_r;
        end
    end

    assign rem  = rem_r;
    assign acc  = acc_r;
    // High during the final step; rem/acc hold the results on the next cycle.
    assign done = busy_r && (cnt_r == '0);

endmodule

// File: rtl/create_d.sv
// Private-exponent generator: D = E^-1 mod L via iterative extended Euclid,
// with an active-low start/ready handshake matching create_e.
module create_d
    import rsa_pkg::*;
#(
    parameter int W = W_KEY
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] L,
    input  logic [W-1:0] E,
    input  logic         start_n,
    output logic [W-1:0] D,
    output logic         ready_n,
    output logic         err
);

    localparam logic [W-1:0] ONE_C = W'(1);
    localparam logic [W-1:0] TWO_C = W'(2);

    cd_state_e state_r;
    cd_state_e state_next_s;

    logic                armed_r;
    logic                illegal_r;
    logic [W-1:0]        l_r;
    logic [W-1:0]        r0_r;
    logic [W-1:0]        r1_r;
    logic signed [W+1:0] t0_r;
    logic signed [W+1:0] t1_r;
    logic [W-1:0]        d_r;
    logic                err_r;
    logic                ready_n_r;

    logic                accept_s;
    logic                illegal_s;
    logic                div_load_s;
    logic                div_done_s;
    logic [W-1:0]        div_rem_s;
    logic signed [W+1:0] div_acc_s;
    logic [W-1:0]        d_fix_s;

    assign accept_s   = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && !start_n && armed_r;
    assign illegal_s  = (E == '0) || (L < TWO_C) || (E >= L);
    assign div_load_s = (state_r == ST_CHECK) && !illegal_r && (r1_r != '0);
    // Modular wrap of a negative coefficient; truncation to W bits is exact.
    assign d_fix_s    = t0_r[W-1:0] + (t0_r[W+1] ? l_r : '0);

    seq_divacc #(.W(W)) u_divacc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load_s),
        .dividend (r0_r),
        .divisor  (r1_r),
        .coef     (t1_r),
        .rem      (div_rem_s),
        .acc      (div_acc_s),
        .done     (div_done_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Euclid sequencing: CHECK -> DIV (W cycles) -> UPD per iteration.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_CHECK;
                else          state_next_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (illegal_r)         state_next_s = ST_DONE;
                else if (r1_r == '0)   state_next_s = ST_FIX;
                else                   state_next_s = ST_DIV;
            end
            ST_DIV: begin
                if (div_done_s) state_next_s = ST_UPD;
                else            state_next_s = ST_DIV;
            end
            ST_UPD:  state_next_s = ST_CHECK;
            ST_FIX:  state_next_s = ST_DONE;
            ST_DONE: begin
                if (accept_s) state_next_s = ST_CHECK;
                else          state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake, Euclid remainders/coefficients and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r   <= 1'b1;
            illegal_r <= 1'b0;
            l_r       <= '0;
            r0_r      <= '0;
            r1_r      <= '0;
            t0_r      <= '0;
            t1_r      <= '0;
            d_r       <= '0;
            err_r     <= 1'b0;
            ready_n_r <= 1'b1;
        end else begin
            if (accept_s)     armed_r <= 1'b0;
            else if (start_n) armed_r <= 1'b1;
            else              armed_r <= armed_r;

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        l_r       <= L;
                        r0_r      <= L;
                        r1_r      <= E;
                        t0_r      <= '0;
                        t1_r      <= (W+2)'(1);
                        illegal_r <= illegal_s;
                        err_r     <= 1'b0;
                        ready_n_r <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (illegal_r) begin
                        d_r       <= '0;
                        err_r     <= 1'b1;
                        ready_n_r <= 1'b0;
                    end
                end
                ST_UPD: begin
                    r0_r <= r1_r;
                    r1_r <= div_rem_s;
                    t0_r <= t1_r;
                    t1_r <= t0_r - div_acc_s;
                end
                ST_FIX: begin
                    if (r0_r != ONE_C) begin
                        d_r   <= '0;
                        err_r <= 1'b1;
                    end else begin
                        d_r   <= d_fix_s;
                        err_r <= 1'b0;
                    end
                    ready_n_r <= 1'b0;
                end
                default: begin
                    d_r <= d_r;
                end
            endcase
        end
    end

    assign D       = d_r;
    assign ready_n = ready_n_r;
    assign err     = err_r;

endmodule
